// File: rtl/run_bit_packer_pkg.sv
// Shared constants for the run-mode bit packer: code modes, field limits
// and the JPEG-LS marker byte that triggers bit stuffing.
package run_bit_packer_pkg;

  localparam logic [1:0] RUN_CONT = 2'b10;
  localparam logic [1:0] RUN_INT  = 2'b11;
  localparam int         MAX_ONES = 24;
  localparam int         MAX_REM  = 9;
  localparam logic [7:0] BYTE_FF  = 8'hFF;

  // Longest code a single triplet can append.
  localparam int         CODE_W   = MAX_ONES + MAX_REM;

endpackage

// File: rtl/run_bit_packer_stuffer.sv
// ls_byte_stuffer: output byte register with JPEG-LS stuffing. Takes 7 bits
// after an 0xFF byte (MSB forced 0), 8 otherwise, and reports bits consumed.
module ls_byte_stuffer
  import run_bit_packer_pkg::*;
#(
  parameter int FILL_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        top8,
  input  logic [FILL_W-1:0] fill,
  input  logic              flushing,
  input  logic              byte_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              stuff,
  output logic [3:0]        taken
);

  logic [7:0] byte_q, byte_d;
  logic       vld_q, stuff_q;
  logic [3:0] need;
  logic       avail, drain, load;

  always_comb begin
    need   = stuff_q ? 4'd7 : 4'd8;
    avail  = (fill >= FILL_W'(need));
    // Under flush a short tail is sent zero-padded; a pending stuff flag
    // with nothing left still forces the trailing 0x00.
    drain  = flushing && ((fill != '0) || stuff_q);
    load   = (!vld_q || byte_ready) && (avail || drain);
    byte_d = stuff_q ? {1'b0, top8[7:1]} : top8;
    taken  = '0;
    if (load) begin
      taken = avail ? need : fill[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q  <= '0;
      vld_q   <= 1'b0;
      stuff_q <= 1'b0;
    end else if (load) begin
      byte_q  <= byte_d;
      vld_q   <= 1'b1;
      stuff_q <= (byte_d == BYTE_FF);
    end else if (byte_ready) begin
      vld_q   <= 1'b0;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = vld_q;
  assign stuff      = stuff_q;

endmodule

// File: rtl/run_bit_packer.sv
// Run-mode code packer: appends (ones, remainder) codes MSB-first into a bit
// accumulator, serialises stuffed bytes, forwards the interruption limit.
module run_bit_packer
  import run_bit_packer_pkg::*;
#(
  parameter int ACC_W  = 64,
  parameter int ONES_W = 6,
  parameter int REM_W  = 11,
  parameter int RLEN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_in,
  input  logic [1:0]        mode_in,
  input  logic [ONES_W-1:0] ones_len,
  input  logic [REM_W-1:0]  rem_code,
  input  logic [RLEN_W-1:0] rem_len,
  input  logic [3:0]        limit_in,
  input  logic              flush,
  output logic              in_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [3:0]        limit_out,
  output logic              limit_valid,
  output logic              flush_done
);

  localparam int FILL_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_rem, add;
  logic              flushing_q, flushing_d;
  logic              flush_done_q, flush_done_d;
  logic [3:0]        limit_q;
  logic              limit_vld_q;

  logic              acc_in, flush_acc, done_now;
  logic [ONES_W-1:0] ones_sat;
  logic [RLEN_W-1:0] rlen_sat;
  logic [CODE_W-1:0] ones_field, rem_field, code;
  logic [3:0]        taken;
  logic              stuff;

  // Space for one worst-case code must remain before a triplet is taken.
  assign in_ready  = !flushing_q && (fill_q <= FILL_W'(ACC_W - CODE_W));
  assign acc_in    = en_in && in_ready;
  assign flush_acc = flush && in_ready;

  ls_byte_stuffer #(.FILL_W(FILL_W)) u_stuffer (
    .clk        (clk),
    .reset      (reset),
    .top8       (acc_q[ACC_W-1 -: 8]),
    .fill       (fill_q),
    .flushing   (flushing_q),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .stuff      (stuff),
    .taken      (taken)
  );

  always_comb begin
    ones_sat   = (ones_len > ONES_W'(MAX_ONES)) ? ONES_W'(MAX_ONES) : ones_len;
    rlen_sat   = (rem_len > RLEN_W'(MAX_REM)) ? RLEN_W'(MAX_REM) : rem_len;
    ones_field = ((CODE_W'(1) << ones_sat) - CODE_W'(1)) << rlen_sat;
    rem_field  = CODE_W'(rem_code) & ((CODE_W'(1) << rlen_sat) - CODE_W'(1));
    code       = ones_field | rem_field;
    add        = '0;
    if (acc_in && ((mode_in == RUN_CONT) || (mode_in == RUN_INT))) begin
      add = FILL_W'(ones_sat) + FILL_W'(rlen_sat);
    end

    // Emit shifts the consumed bits out of the top; the new code lands
    // directly below whatever remains.
    fill_rem = fill_q - FILL_W'(taken);
    acc_d    = acc_q << taken;
    if (add != '0) begin
      acc_d = acc_d | (ACC_W'(code) << (FILL_W'(ACC_W) - fill_rem - add));
    end
    fill_d = fill_rem + add;

    done_now = (flushing_q || flush_acc) && (fill_q == '0) && (add == '0)
               && !stuff && (!byte_valid || byte_ready);
    flush_done_d = done_now;
    flushing_d   = flushing_q;
    if (done_now) begin
      flushing_d = 1'b0;
    end else if (flush_acc) begin
      flushing_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flushing_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flushing_q   <= flushing_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      limit_q     <= '0;
      limit_vld_q <= 1'b0;
    end else begin
      limit_vld_q <= acc_in && (mode_in == RUN_INT);
      if (acc_in && (mode_in == RUN_INT)) begin
        limit_q <= limit_in;
      end
    end
  end

  assign limit_out   = limit_q;
  assign limit_valid = limit_vld_q;
  assign flush_done  = flush_done_q;

endmodule

// File: tb/tb_run_bit_packer.sv
// Bench for run_bit_packer: directed scenarios plus random triplet streams
// compared against a bit-queue model of the stuffed byte stream.
module tb_run_bit_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_in = 1'b0;
  logic [1:0]  mode_in = 2'b00;
  logic [5:0]  ones_len = '0;
  logic [10:0] rem_code = '0;
  logic [3:0]  rem_len = '0;
  logic [3:0]  limit_in = '0;
  logic        flush = 1'b0;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [3:0]  limit_out;
  logic        limit_valid;
  logic        flush_done;

  logic rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;
  logic rr = 1'b1;
  assign byte_ready = rand_rdy ? rr : rdy_fixed;

  int checks = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] got[$];
  int cyc = 0, last_hs = -1, done_cyc = -1, done_cnt = 0;
  int rd = 0;

  // Reference model state
  bit         mq[$];
  bit         mstuff = 1'b0;
  logic [7:0] exp_q[$];

  run_bit_packer dut (
    .clk(clk), .reset(reset), .en_in(en_in), .mode_in(mode_in),
    .ones_len(ones_len), .rem_code(rem_code), .rem_len(rem_len),
    .limit_in(limit_in), .flush(flush), .in_ready(in_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .limit_out(limit_out), .limit_valid(limit_valid), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rr = ($urandom_range(0, 3) != 0);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && byte_valid && byte_ready) begin
      got.push_back(byte_out);
      last_hs = cyc;
    end
    if (flush_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic void emit_one();
    int n = mstuff ? 7 : 8;
    int b = 0;
    for (int i = 0; i < n; i++) begin
      b = b << 1;
      if (mq.size() > 0) b = b | int'(mq.pop_front());
    end
    exp_q.push_back(8'(b));
    mstuff = (b == 255);
  endfunction

  function automatic void model_push(input logic [1:0] m, input int ones, input int rem, input int rl);
    if (m[1]) begin
      for (int i = 0; i < ones; i++) mq.push_back(1'b1);
      for (int i = rl - 1; i >= 0; i--) mq.push_back(rem[i]);
    end
    while (mq.size() >= (mstuff ? 7 : 8)) emit_one();
  endfunction

  function automatic void model_flush();
    while (mq.size() > 0) emit_one();
    if (mstuff) begin
      exp_q.push_back(8'h00);
      mstuff = 1'b0;
    end
  endfunction

  task automatic send(input bit en, input logic [1:0] m, input int ones, input int rem,
                      input int rl, input int lim, input bit fl, input string nm);
    int t = 0;
    @(negedge clk);
    en_in = en; mode_in = m; ones_len = 6'(ones); rem_code = 11'(rem);
    rem_len = 4'(rl); limit_in = 4'(lim); flush = fl;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++; failures++;
      $display("FAIL %s accept_timeout in_ready=%0b required=1", nm, in_ready);
      en_in = 0; flush = 0;
      return;
    end
    @(posedge clk);
    if (en) model_push(m, ones, rem, rl);
    if (fl) model_flush();
    @(negedge clk);
    en_in = 0; flush = 0;
    checks++;
    if (limit_valid !== (en && m == 2'b11)) begin
      failures++;
      $display("FAIL %s limit_valid got=%0b required=%0b", nm, limit_valid, en && m == 2'b11);
    end
    if (en && m == 2'b11) begin
      checks++;
      if (limit_out !== 4'(lim)) begin
        failures++;
        $display("FAIL %s limit_out got=%0h required=%0h", nm, limit_out, 4'(lim));
      end
    end
  endtask

  task automatic wait_done(input int start, input string nm);
    int t = 0;
    while (done_cnt <= start && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt <= start) begin
      failures++;
      $display("FAIL %s flush_done_timeout got=%0d pulses required>%0d", nm, done_cnt, start);
    end
  endtask

  task automatic check_stream(input string nm);
    int t = 0;
    int n = exp_q.size();
    while ((got.size() - rd) < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got.size() - rd != n) begin
      failures++;
      $display("FAIL %s byte_count got=%0d required=%0d", nm, got.size() - rd, n);
    end
    for (int i = 0; i < n; i++) begin
      if (rd + i < got.size()) begin
        checks++;
        if (got[rd+i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s byte[%0d] got=%02h required=%02h", nm, i, got[rd+i], exp_q[i]);
        end
        if (i > 0 && got[rd+i-1] == 8'hFF) begin
          checks++;
          if (got[rd+i][7] !== 1'b0) begin
            failures++;
            $display("FAIL %s stuff_msb byte[%0d] got=%02h required_msb=0", nm, i, got[rd+i]);
          end
        end
      end
    end
    rd = got.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_valid, byte_out, limit_valid, limit_out, flush_done, in_ready} !== {1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset outputs got=%0b_%02h_%0b_%0h_%0b_%0b required=0_00_0_0_0_1",
               byte_valid, byte_out, limit_valid, limit_out, flush_done, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ff_stuff_flush();
    int d0 = done_cnt;
    int base = rd;
    send(1, 2'b10, 8, 0, 0, 0, 0, "t1_send");
    send(0, 2'b00, 0, 0, 0, 0, 1, "t1_flush");
    wait_done(d0, "t1");
    checks++;
    if (got.size() < base + 2 || got[base] !== 8'hFF || got[base+1] !== 8'h00) begin
      failures++;
      $display("FAIL t1_const bytes got_count=%0d required FF 00", got.size() - base);
    end
    checks++;
    if (done_cyc !== last_hs + 1) begin
      failures++;
      $display("FAIL t1_done_timing got=%0d required=%0d", done_cyc, last_hs + 1);
    end
    check_stream("t1");
  endtask

  task automatic test_interrupt_limit();
    int d0 = done_cnt;
    int base = rd;
    send(1, 2'b11, 3, 5, 4, 9, 1, "t2_send");
    wait_done(d0, "t2");
    checks++;
    if (got.size() < base + 1 || got[base] !== 8'hEA) begin
      failures++;
      $display("FAIL t2_const byte got_count=%0d required EA", got.size() - base);
    end
    check_stream("t2");
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int rem = $urandom_range(0, 2047);
    int d0;
    rdy_fixed = 1'b0;
    @(negedge clk);
    en_in = 1; mode_in = 2'b10; ones_len = 6'd24; rem_code = 11'(rem); rem_len = 4'd9;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        accepts++;
        @(posedge clk);
        model_push(2'b10, 24, rem, 9);
      end
      @(negedge clk);
    end
    en_in = 0;
    checks++;
    if (accepts !== 2) begin
      failures++;
      $display("FAIL t3_accepts got=%0d required=2", accepts);
    end
    checks++;
    if (in_ready !== 1'b0 || byte_valid !== 1'b1) begin
      failures++;
      $display("FAIL t3_stall in_ready=%0b byte_valid=%0b required 0 1", in_ready, byte_valid);
    end
    rdy_fixed = 1'b1;
    d0 = done_cnt;
    send(0, 2'b00, 0, 0, 0, 0, 1, "t3_flush");
    wait_done(d0, "t3");
    check_stream("t3");
  endtask

  task automatic test_no_bits();
    int base = rd;
    send(1, 2'b00, 5, 0, 0, 3, 0, "t4_mode00");
    send(1, 2'b01, 7, 3, 2, 3, 0, "t4_mode01");
    send(0, 2'b00, 0, 0, 0, 0, 1, "t4_flush");
    checks++;
    if (flush_done !== 1'b1) begin
      failures++;
      $display("FAIL t4_empty_flush flush_done got=%0b required=1", flush_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got.size() !== base) begin
      failures++;
      $display("FAIL t4_no_bytes got=%0d required=0", got.size() - base);
    end
  endtask

  task automatic test_stuff_chain();
    int d0 = done_cnt;
    send(1, 2'b10, 16, 0, 0, 0, 0, "t5_a");
    send(1, 2'b10, 7, 0, 1, 0, 1, "t5_b");
    wait_done(d0, "t5");
    check_stream("t5");
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      int d0;
      rand_rdy = 1'b1;
      for (int k = 0; k < 30; k++) begin
        send(1, 2'($urandom_range(0, 3)), $urandom_range(0, 24), $urandom_range(0, 2047),
             $urandom_range(0, 9), $urandom_range(0, 15), 0, "rnd_send");
      end
      d0 = done_cnt;
      send(($urandom_range(0, 1) == 1), 2'b10, 24, 0, 0, 0, 1, "rnd_flush");
      wait_done(d0, "rnd");
      rand_rdy = 1'b0;
      check_stream("rnd");
    end
  endtask

  task automatic test_reset_midstream();
    int d0;
    rdy_fixed = 1'b0;
    send(1, 2'b10, 20, 0, 0, 0, 0, "t6_fill");
    repeat (2) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b1) begin
      failures++;
      $display("FAIL t6_pre byte_valid got=%0b required=1", byte_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (byte_valid !== 1'b0 || in_ready !== 1'b1 || byte_out !== 8'h00) begin
      failures++;
      $display("FAIL t6_reset byte_valid=%0b in_ready=%0b byte_out=%02h required 0 1 00",
               byte_valid, in_ready, byte_out);
    end
    mq.delete(); mstuff = 1'b0; exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd = got.size();
    rdy_fixed = 1'b1;
    d0 = done_cnt;
    send(1, 2'b11, 3, 5, 4, 6, 1, "t6_cold");
    wait_done(d0, "t6");
    checks++;
    if (got.size() != rd + 1 || got[rd] !== 8'hEA) begin
      failures++;
      $display("FAIL t6_cold bytes got_count=%0d required one EA", got.size() - rd);
    end
    check_stream("t6");
  endtask

  initial begin
    test_reset();
    test_ff_stuff_flush();
    test_interrupt_limit();
    test_backpressure();
    test_no_bits();
    test_stuff_chain();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
